// File: rtl/rx_iq_fifo_if.sv
// Bundles the DDC push side, the parallel-bus read handshake and the status/head outputs of rx_iq_fifo.
// The slave modport belongs to the FIFO. The master modport belongs to the producer/consumer side.
interface rx_iq_fifo_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int IQ_WIDTH   = 24
);
    logic signed [IQ_WIDTH-1:0] DDC_RX1_I;
    logic signed [IQ_WIDTH-1:0] DDC_RX1_Q;
    logic signed [IQ_WIDTH-1:0] DDC_RX2_I;
    logic signed [IQ_WIDTH-1:0] DDC_RX2_Q;
    logic                       DDC_valid;
    logic                       IQ_RX_READ_REQ;
    logic                       IQ_RX_READ_CLK;
    logic                       overrun_clear;

    logic signed [IQ_WIDTH-1:0] RX1_I;
    logic signed [IQ_WIDTH-1:0] RX1_Q;
    logic signed [IQ_WIDTH-1:0] RX2_I;
    logic signed [IQ_WIDTH-1:0] RX2_Q;
    logic                       in_empty;
    logic                       iq_overrun;
    logic                       iq_underrun;
    logic [DEPTH_LOG2:0]        fill_level;

    modport master (
        output DDC_RX1_I, DDC_RX1_Q, DDC_RX2_I, DDC_RX2_Q, DDC_valid,
        output IQ_RX_READ_REQ, IQ_RX_READ_CLK, overrun_clear,
        input  RX1_I, RX1_Q, RX2_I, RX2_Q, in_empty, iq_overrun, iq_underrun, fill_level
    );

    modport slave (
        input  DDC_RX1_I, DDC_RX1_Q, DDC_RX2_I, DDC_RX2_Q, DDC_valid,
        input  IQ_RX_READ_REQ, IQ_RX_READ_CLK, overrun_clear,
        output RX1_I, RX1_Q, RX2_I, RX2_Q, in_empty, iq_overrun, iq_underrun, fill_level
    );
endinterface

// File: rtl/rx_iq_fifo.sv
// Show-ahead IQ sample FIFO between the DDC and the STM32 parallel-bus reader, with sticky overrun/underrun flags.
// Optional RX2 storage is enabled by defining RX2_CHANNEL_EN. Otherwise the RX2 outputs are tied to zero.
module rx_iq_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int IQ_WIDTH   = 24
) (
    input  logic         clk_in,
    input  logic         reset_n,
    rx_iq_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef RX2_CHANNEL_EN
    localparam int ENTRY_W = 4 * IQ_WIDTH;
`else
    localparam int ENTRY_W = 2 * IQ_WIDTH;
`endif
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

    logic [ENTRY_W-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_rd_clk_d;
    logic                  r_overrun;
    logic                  r_underrun;

    logic                  w_pop_req;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic                  w_overrun_set;
    logic                  w_underrun_set;
    logic [ENTRY_W-1:0]    w_wr_entry;
    logic [ENTRY_W-1:0]    w_head;

    // A pop is the rising edge of the consumer read clock while its request is held.
    assign w_pop_req = bus.IQ_RX_READ_CLK & ~r_rd_clk_d & bus.IQ_RX_READ_REQ;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push_ok      = bus.DDC_valid & (~w_full | w_pop_req);
    assign w_pop_ok       = w_pop_req & ~w_empty;
    assign w_overrun_set  = bus.DDC_valid & ~w_push_ok;
    assign w_underrun_set = w_pop_req & w_empty;

`ifdef RX2_CHANNEL_EN
    assign w_wr_entry = {bus.DDC_RX2_Q, bus.DDC_RX2_I, bus.DDC_RX1_Q, bus.DDC_RX1_I};
`else
    logic w_unused_rx2;
    assign w_unused_rx2 = ^{bus.DDC_RX2_Q, bus.DDC_RX2_I};
    assign w_wr_entry   = {bus.DDC_RX1_Q, bus.DDC_RX1_I};
`endif

    // NOTE: storage has no reset; validity is tracked by the count, so stale words are never presented.
    always_ff @(posedge clk_in) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // NOTE: all state below updates with non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_clk_d <= 1'b0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_rd_clk_d <= bus.IQ_RX_READ_CLK;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - CNT_ONE;
            end
            // Set wins over a clear arriving on the same edge.
            r_overrun  <= w_overrun_set  | (r_overrun  & ~bus.overrun_clear);
            r_underrun <= w_underrun_set | (r_underrun & ~bus.overrun_clear);
        end
    end

    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

    assign bus.RX1_I = w_head[IQ_WIDTH-1:0];
    assign bus.RX1_Q = w_head[2*IQ_WIDTH-1:IQ_WIDTH];
`ifdef RX2_CHANNEL_EN
    assign bus.RX2_I = w_head[3*IQ_WIDTH-1:2*IQ_WIDTH];
    assign bus.RX2_Q = w_head[4*IQ_WIDTH-1:3*IQ_WIDTH];
`else
    assign bus.RX2_I = '0;
    assign bus.RX2_Q = '0;
`endif

    assign bus.in_empty    = w_empty;
    assign bus.fill_level  = r_count;
    assign bus.iq_overrun  = r_overrun;
    assign bus.iq_underrun = r_underrun;
endmodule
